uart_tx_sched: RTL and testbench

Round-robin scheduler that shares a single UART transmitter among several byte producers and generates its baud tick. It sits between the requesters and the transmitter. For each granted byte it drives the transmitter's `data_in`, `tx_start` and `tick` inputs, then waits for `tx_done`. A watchdog flags a transmitter that never completes.

---
 rtl/uart_tx_sched.sv | 161 ++++++++++++++++
 tb/tb_uart_tx_sched.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_sched.sv
// uart_tx_sched
// Round-robin scheduler that shares one UART transmitter among NUM_REQ byte
// producers and generates the transmitter's baud tick. Each granted byte is
// presented on tx_data with tx_start held until a baud tick is issued. The
// block then waits for tx_done. A watchdog flags a transmitter that never
// completes.
//
// Ports
//   clk, rst_n          system clock, async active-low reset
//   req, req_data       per-requester request level and byte (8 bits each)
//   grant, done         one-hot single-cycle pulses: byte accepted / sent
//   busy                high whenever the FSM is not IDLE
//   timeout_err         sticky watchdog flag, cleared by err_clr
//   tx_data, tx_start   to transmitter data_in / tx_start
//   tick                baud strobe to transmitter
//   tx_done             frame-complete from transmitter
//
// state | meaning
// IDLE  | arbitrate among active requests
// START | tx_start high, waiting for the next baud tick
// WAIT  | frame in flight, watchdog running until tx_done
module uart_tx_sched #(
  parameter int NUM_REQ = 4,
  parameter int CLK_DIV = 16,
  parameter int TIMEOUT = 4096
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [8*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   grant,
  output logic [NUM_REQ-1:0]   done,
  output logic                 busy,
  output logic                 timeout_err,
  input  logic                 err_clr,
  output logic [7:0]           tx_data,
  output logic                 tx_start,
  output logic                 tick,
  input  logic                 tx_done
);

  localparam int LW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    START = 2'b01,
    WAIT  = 2'b10
  } state_t;

  state_t             state_q;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               tick_q;
  logic [TW-1:0]      wd_q;
  logic [LW-1:0]      last_q;
  logic [NUM_REQ-1:0] grant_q, done_q;
  logic [7:0]         tx_data_q;
  logic               tx_start_q;
  logic               err_q;

  logic [LW-1:0]      win;
  logic               found;
  int                 idx;
  logic [7:0]         win_data;

  // Baud divider. tick_q is registered one cycle ahead so that it is high
  // exactly while the counter sits at CLK_DIV-1.
  always_comb begin
    cnt_d = (cnt_q == CW'(CLK_DIV - 1)) ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= (cnt_d == CW'(CLK_DIV - 1));
    end
  end

  // Round-robin search starting just after the last winner.
  always_comb begin
    win   = last_q;
    found = 1'b0;
    idx   = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(last_q) + k) % NUM_REQ;
      if (!found && req[LW'(idx)]) begin
        found = 1'b1;
        win   = LW'(idx);
      end
    end
  end

  assign win_data = req_data[{win, 3'b000} +: 8];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      wd_q       <= '0;
      last_q     <= LW'(NUM_REQ - 1);
      grant_q    <= '0;
      done_q     <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      grant_q <= '0;
      done_q  <= '0;
      // A watchdog set later in this block overrides the clear.
      if (err_clr) err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (|req) begin
            tx_data_q  <= win_data;
            last_q     <= win;
            grant_q    <= NUM_REQ'(1) << win;
            tx_start_q <= 1'b1;
            state_q    <= START;
          end
        end
        START: begin
          if (tick_q) begin
            tx_start_q <= 1'b0;
            wd_q       <= '0;
            state_q    <= WAIT;
          end
        end
        WAIT: begin
          if (tx_done) begin
            done_q  <= NUM_REQ'(1) << last_q;
            wd_q    <= '0;
            state_q <= IDLE;
          end else if (wd_q == TW'(TIMEOUT - 1)) begin
            err_q   <= 1'b1;
            wd_q    <= '0;
            state_q <= IDLE;
          end else begin
            wd_q <= wd_q + 1'b1;
          end
        end
        default: begin
          tx_start_q <= 1'b0;
          wd_q       <= '0;
          state_q    <= IDLE;
        end
      endcase
    end
  end

  assign grant       = grant_q;
  assign done        = done_q;
  assign busy        = (state_q != IDLE);
  assign timeout_err = err_q;
  assign tx_data     = tx_data_q;
  assign tx_start    = tx_start_q;
  assign tick        = tick_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Self-checking bench for uart_tx_sched: randomized transfers checked against
// a transaction-level model of the arbitration, watchdog and baud rules.
module tb_uart_tx_sched;

  localparam int NR = 4;
  localparam int CD = 16;
  localparam int TO = 64;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [NR-1:0] req = '0;
  logic [8*NR-1:0] req_data = '0;
  logic          err_clr = 1'b0;
  logic          tx_done = 1'b0;
  logic [NR-1:0] grant, done;
  logic          busy, timeout_err, tx_start, tick;
  logic [7:0]    tx_data;

  uart_tx_sched #(.NUM_REQ(NR), .CLK_DIV(CD), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data),
    .grant(grant), .done(done), .busy(busy), .timeout_err(timeout_err),
    .err_clr(err_clr), .tx_data(tx_data), .tx_start(tx_start),
    .tick(tick), .tx_done(tx_done)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Edges since the last reset release: tick is due when this is CD-1 mod CD.
  int ecnt = 0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) ecnt <= 0;
    else        ecnt <= ecnt + 1;
  end

  always @(negedge clk) begin
    chk("tick_phase", 32'(tick), 32'(rst_n && (ecnt % CD == CD - 1)));
  end

  int last_m = NR - 1;
  bit err_m  = 1'b0;

  function automatic int arb(input logic [NR-1:0] r, input int last);
    int i;
    for (int k = 1; k <= NR; k++) begin
      i = (last + k) % NR;
      if (r[i]) return i;
    end
    return -1;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One transfer. dly = WAIT cycle (1-based) in which tx_done is driven;
  // 0 or anything above TO means the transmitter never answers.
  task automatic xfer(input logic [NR-1:0] reqv, input bit keep, input int dly,
                      input bit early, input bit clr_at_to);
    int w;
    int n;
    bit tprev;
    for (int i = 0; i < NR; i++) req_data[8*i +: 8] = 8'($urandom);
    req = reqv;
    w = arb(reqv, last_m);
    step();
    chk("grant", 32'(grant), 32'(1 << w));
    chk("tx_data", 32'(tx_data), 32'(req_data[8*w +: 8]));
    chk("tx_start", 32'(tx_start), 1);
    chk("busy_start", 32'(busy), 1);
    last_m = w;
    if (!keep) req = '0;
    n = 0;
    tprev = 1'b0;
    if (early) tx_done = 1'b1;
    do begin
      tprev = tick;
      step();
      tx_done = 1'b0;
      n++;
    end while (tx_start && n <= CD);
    chk("start_len_in_range", 32'(n >= 1 && n <= CD), 1);
    chk("start_fall_after_tick", 32'(tprev), 1);
    chk("busy_wait", 32'(busy), 1);
    for (int c = 1; c <= TO; c++) begin
      tx_done = (c == dly);
      err_clr = clr_at_to && (c == TO);
      step();
      tx_done = 1'b0;
      err_clr = 1'b0;
      if (c == dly) begin
        chk("done", 32'(done), 32'(1 << w));
        chk("busy_after_done", 32'(busy), 0);
        chk("grant_after_done", 32'(grant), 0);
        break;
      end
      if (c == TO) begin
        err_m = 1'b1;
        chk("to_err", 32'(timeout_err), 1);
        chk("to_nodone", 32'(done), 0);
        chk("to_idle", 32'(busy), 0);
      end else if (done != '0 || !busy) begin
        chk("wait_quiet", 32'({done, busy}), 32'h1);
      end
    end
    chk("err_flag", 32'(timeout_err), 32'(err_m));
  endtask

  task automatic idle_chk(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      tx_done = 1'($urandom);
      step();
      tx_done = 1'b0;
      chk("idle_grant", 32'(grant), 0);
      chk("idle_done", 32'(done), 0);
      chk("idle_busy", 32'(busy), 0);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk(tag, 32'({grant, done, busy, timeout_err, tx_data, tx_start, tick}), 0);
  endtask

  initial begin
    int n;
    bit tmo;
    int dly;

    // Reset and tick spacing
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset_outputs");
    rst_n = 1'b1;
    n = 0;
    do begin step(); n++; end while (!tick && n < 40);
    // Counter runs 0..15 after release, so tick arrives in the 16th cycle.
    chk("first_tick_edges", n, CD - 1);
    for (int r = 0; r < 3; r++) begin
      n = 0;
      do begin step(); n++; end while (!tick && n < 40);
      chk("tick_period", n, CD);
    end

    // Single byte, with a stale tx_done during IDLE and START
    idle_chk(3);
    xfer(4'b0001, 1'b0, 40, 1'b1, 1'b0);

    // Round-robin fairness with all requests held
    for (int r = 0; r < 5; r++) xfer(4'b1111, 1'b1, $urandom_range(1, TO), 1'b0, 1'b0);
    req = '0;
    idle_chk(2);

    // Pointer wrap and withdrawal
    xfer(4'b0100, 1'b0, 5, 1'b0, 1'b0);
    xfer(4'b1001, 1'b0, 7, 1'b0, 1'b0);
    idle_chk(20);

    // Watchdog: expiry, clear, clear colliding with expiry, done at the limit
    xfer(4'b0010, 1'b0, 0, 1'b0, 1'b0);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    err_m = 1'b0;
    chk("err_cleared", 32'(timeout_err), 0);
    xfer(4'b0010, 1'b0, TO - 1, 1'b0, 1'b0);
    xfer(4'b0010, 1'b0, TO, 1'b0, 1'b0);
    xfer(4'b1000, 1'b0, 0, 1'b0, 1'b1);

    // Reset in WAIT: leave pointer at 0 with the error flag set, then reset
    xfer(4'b0001, 1'b0, 3, 1'b0, 1'b0);
    req = 4'b0001;
    step();
    req = '0;
    n = 0;
    while (tx_start && n < 40) begin step(); n++; end
    chk("reached_wait", 32'({tx_start, busy}), 32'b01);
    step();
    step();
    rst_n = 1'b0;
    #1;
    chk_all_zero("reset_mid_wait");
    err_m = 1'b0;
    last_m = NR - 1;
    step();
    step();
    rst_n = 1'b1;
    xfer(4'b0101, 1'b0, 4, 1'b0, 1'b0);
    xfer(4'b0100, 1'b0, 4, 1'b0, 1'b0);

    // Randomized traffic
    for (int r = 0; r < 25; r++) begin
      tmo = ($urandom_range(0, 5) == 0);
      dly = tmo ? 0 : $urandom_range(1, TO);
      xfer(4'($urandom_range(1, 15)), 1'($urandom), dly, 1'($urandom), 1'($urandom) & tmo);
      if ($urandom_range(0, 3) == 0) begin
        req = '0;
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        err_m = 1'b0;
        chk("rand_err_clr", 32'(timeout_err), 0);
      end
    end
    req = '0;
    idle_chk(2);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
